// File: rtl/a6_pulse_detect.sv
// Pulse detector on the level-6 fp32 approximation stream: hysteresis trigger,
// peak/width capture, holdoff, and a single-entry event register with drop count.
`timescale 1ns/1ps
module a6_pulse_detect #(
  parameter logic [31:0] THRESH_HI = 32'h3F800000,
  parameter logic [31:0] THRESH_LO = 32'h3F000000,
  parameter int unsigned HOLDOFF   = 4,
  parameter int unsigned MAX_WIDTH = 64
) (
  input  logic        clk_78_125,
  input  logic        rstn,
  input  logic        din_valid,
  input  logic [31:0] a6_0,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [31:0] evt_peak,
  output logic [31:0] evt_peak_ts,
  output logic [15:0] evt_width,
  output logic [15:0] evt_drop_cnt,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TS_W   = 32;
  localparam int unsigned WID_W  = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [WID_W-1:0] MAX_W     = WID_W'(MAX_WIDTH);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF);

  // Monotonic unsigned key for fp32 ordering (-0 sorts below +0, NaNs by bits)
  function automatic logic [DATA_W-1:0] fkey(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? ~x : (x ^ 32'h80000000);
  endfunction

  localparam logic [DATA_W-1:0] KEY_HI = THRESH_HI[31] ? ~THRESH_HI : (THRESH_HI ^ 32'h80000000);
  localparam logic [DATA_W-1:0] KEY_LO = THRESH_LO[31] ? ~THRESH_LO : (THRESH_LO ^ 32'h80000000);

  logic [1:0]        state, state_nx;
  logic [TS_W-1:0]   ts, ts_nx;
  logic [DATA_W-1:0] peak, peak_nx;
  logic [TS_W-1:0]   peak_ts, peak_ts_nx;
  logic [WID_W-1:0]  width, width_nx;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_nx;
  logic              evt_valid_nx;
  logic [DATA_W-1:0] evt_peak_nx;
  logic [TS_W-1:0]   evt_peak_ts_nx;
  logic [WID_W-1:0]  evt_width_nx;
  logic [WID_W-1:0]  evt_drop_cnt_nx;
  logic              busy_nx;
  logic              pulse_end;
  logic [DATA_W-1:0] sample_key;

  // State and datapath registers
  always_ff @(posedge clk_78_125 or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      ts           <= '0;
      peak         <= '0;
      peak_ts      <= '0;
      width        <= '0;
      hold_cnt     <= '0;
      evt_valid    <= 1'b0;
      evt_peak     <= '0;
      evt_peak_ts  <= '0;
      evt_width    <= '0;
      evt_drop_cnt <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      ts           <= ts_nx;
      peak         <= peak_nx;
      peak_ts      <= peak_ts_nx;
      width        <= width_nx;
      hold_cnt     <= hold_cnt_nx;
      evt_valid    <= evt_valid_nx;
      evt_peak     <= evt_peak_nx;
      evt_peak_ts  <= evt_peak_ts_nx;
      evt_width    <= evt_width_nx;
      evt_drop_cnt <= evt_drop_cnt_nx;
      busy         <= busy_nx;
    end
  end

  // Next-state, pulse tracking and event register update
  always_comb begin
    state_nx        = state;
    ts_nx           = ts;
    peak_nx         = peak;
    peak_ts_nx      = peak_ts;
    width_nx        = width;
    hold_cnt_nx     = hold_cnt;
    evt_valid_nx    = evt_valid;
    evt_peak_nx     = evt_peak;
    evt_peak_ts_nx  = evt_peak_ts;
    evt_width_nx    = evt_width;
    evt_drop_cnt_nx = evt_drop_cnt;
    pulse_end       = 1'b0;
    sample_key      = fkey(a6_0);

    if (din_valid) begin
      ts_nx = ts + TS_W'(1);
      case (state)
        S_IDLE: begin
          if (sample_key > KEY_HI) begin
            state_nx   = S_PULSE;
            peak_nx    = a6_0;
            peak_ts_nx = ts;
            width_nx   = WID_W'(1);
            pulse_end  = (MAX_W == WID_W'(1));
          end
        end
        S_PULSE: begin
          if (sample_key < KEY_LO) begin
            pulse_end = 1'b1;
          end else begin
            width_nx = width + WID_W'(1);
            if (sample_key > fkey(peak)) begin
              peak_nx    = a6_0;
              peak_ts_nx = ts;
            end
            pulse_end = (width_nx == MAX_W);
          end
        end
        S_HOLD: begin
          hold_cnt_nx = hold_cnt - CNT_W'(1);
          if (hold_cnt_nx == '0) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase

      if (pulse_end) begin
        hold_cnt_nx = HOLD_INIT;
        state_nx    = (HOLD_INIT == '0) ? S_IDLE : S_HOLD;
      end
    end

    // A held, unaccepted event wins; a new event arriving then is counted as lost
    if (pulse_end) begin
      if (!evt_valid || evt_ready) begin
        evt_valid_nx   = 1'b1;
        evt_peak_nx    = peak_nx;
        evt_peak_ts_nx = peak_ts_nx;
        evt_width_nx   = width_nx;
      end else if (evt_drop_cnt != 16'hFFFF) begin
        evt_drop_cnt_nx = evt_drop_cnt + WID_W'(1);
      end
    end else if (evt_ready) begin
      evt_valid_nx = 1'b0;
    end

    busy_nx = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_a6_pulse_detect.sv
// Directed bench for a6_pulse_detect: trigger/peak/width, hysteresis, sign
// ordering, backpressure, simultaneous accept, forced end and mid-pulse reset.
`timescale 1ns/1ps
module tb_a6_pulse_detect;

  logic        clk_78_125 = 1'b0;
  logic        rstn;
  logic        din_valid;
  logic [31:0] a6_0;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_peak;
  logic [31:0] evt_peak_ts;
  logic [15:0] evt_width;
  logic [15:0] evt_drop_cnt;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  a6_pulse_detect dut (
    .clk_78_125  (clk_78_125),
    .rstn        (rstn),
    .din_valid   (din_valid),
    .a6_0        (a6_0),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_peak    (evt_peak),
    .evt_peak_ts (evt_peak_ts),
    .evt_width   (evt_width),
    .evt_drop_cnt(evt_drop_cnt),
    .busy        (busy)
  );

  always #6 clk_78_125 = ~clk_78_125;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one valid sample across one edge; returns #1 after that edge
  task automatic send(input logic [31:0] d);
    din_valid = 1'b1;
    a6_0      = d;
    @(posedge clk_78_125);
    #1;
    din_valid = 1'b0;
    a6_0      = 32'h0;
  endtask

  task automatic idle_cycle();
    @(posedge clk_78_125);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk_78_125);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    din_valid = 1'b0;
    a6_0      = 32'h0;
    evt_ready = 1'b0;
    #3;
    chk("rst_evt_valid", {31'h0, evt_valid}, 32'h0);
    chk("rst_peak", evt_peak, 32'h0);
    chk("rst_peak_ts", evt_peak_ts, 32'h0);
    chk("rst_width", {16'h0, evt_width}, 32'h0);
    chk("rst_drop", {16'h0, evt_drop_cnt}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk_78_125);
    #1;
    rstn = 1'b1;

    // Basic pulse
    send(32'h3E800000);
    chk("basic_busy0", {31'h0, busy}, 32'h0);
    send(32'h40000000);
    chk("basic_busy1", {31'h0, busy}, 32'h1);
    send(32'h40400000);
    send(32'h40000000);
    chk("basic_no_evt_yet", {31'h0, evt_valid}, 32'h0);
    send(32'h3E800000);
    chk("basic_evt_valid", {31'h0, evt_valid}, 32'h1);
    chk("basic_peak", evt_peak, 32'h40400000);
    chk("basic_peak_ts", evt_peak_ts, 32'd2);
    chk("basic_width", {16'h0, evt_width}, 32'd3);
    chk("basic_busy_hold", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 3; i++) send(32'h40400000);
    chk("hold_busy_3", {31'h0, busy}, 32'h1);
    send(32'h40400000);
    chk("hold_busy_4", {31'h0, busy}, 32'h0);
    chk("hold_held_evt", evt_peak, 32'h40400000);
    evt_ready = 1'b1;
    idle_cycle();
    evt_ready = 1'b0;
    chk("basic_evt_clear", {31'h0, evt_valid}, 32'h0);

    // Hysteresis and first-maximum tie
    do_reset();
    send(32'h40000000);
    send(32'h3F400000);
    send(32'h40000000);
    chk("hyst_no_evt", {31'h0, evt_valid}, 32'h0);
    send(32'h3E800000);
    chk("hyst_evt_valid", {31'h0, evt_valid}, 32'h1);
    chk("hyst_width", {16'h0, evt_width}, 32'd3);
    chk("hyst_peak", evt_peak, 32'h40000000);
    chk("hyst_peak_ts", evt_peak_ts, 32'd0);

    // Sign ordering and threshold equality; invalid cycles change nothing
    do_reset();
    send(32'hBF800000);
    chk("sign_busy_a", {31'h0, busy}, 32'h0);
    send(32'h80000000);
    chk("sign_busy_b", {31'h0, busy}, 32'h0);
    send(32'h3F800000);
    chk("sign_busy_c", {31'h0, busy}, 32'h0);
    a6_0 = 32'h40400000;
    idle_cycle();
    chk("invalid_busy", {31'h0, busy}, 32'h0);
    chk("sign_no_evt", {31'h0, evt_valid}, 32'h0);

    // Backpressure: second event dropped, first held
    do_reset();
    send(32'h40000000);
    send(32'h00000000);
    for (int i = 0; i < 5; i++) send(32'h00000000);
    send(32'h40400000);
    send(32'h40400000);
    send(32'h00000000);
    chk("bp_evt_valid", {31'h0, evt_valid}, 32'h1);
    chk("bp_peak", evt_peak, 32'h40000000);
    chk("bp_peak_ts", evt_peak_ts, 32'd0);
    chk("bp_width", {16'h0, evt_width}, 32'd1);
    chk("bp_drop", {16'h0, evt_drop_cnt}, 32'd1);

    // Simultaneous accept and load
    do_reset();
    send(32'h40000000);
    send(32'h00000000);
    for (int i = 0; i < 4; i++) send(32'h00000000);
    send(32'h40400000);
    send(32'h40400000);
    evt_ready = 1'b1;
    send(32'h00000000);
    evt_ready = 1'b0;
    chk("sim_evt_valid", {31'h0, evt_valid}, 32'h1);
    chk("sim_peak", evt_peak, 32'h40400000);
    chk("sim_peak_ts", evt_peak_ts, 32'd6);
    chk("sim_width", {16'h0, evt_width}, 32'd2);
    chk("sim_drop", {16'h0, evt_drop_cnt}, 32'd0);

    // Forced end at MAX_WIDTH, re-trigger after holdoff, reset mid-pulse
    do_reset();
    for (int i = 0; i < 63; i++) send(32'h40000000);
    chk("force_no_evt_yet", {31'h0, evt_valid}, 32'h0);
    send(32'h40000000);
    chk("force_evt_valid", {31'h0, evt_valid}, 32'h1);
    chk("force_width", {16'h0, evt_width}, 32'd64);
    chk("force_peak_ts", evt_peak_ts, 32'd0);
    chk("force_peak", evt_peak, 32'h40000000);
    for (int i = 0; i < 4; i++) send(32'h40000000);
    chk("force_idle_after_hold", {31'h0, busy}, 32'h0);
    send(32'h40000000);
    chk("force_retrigger_busy", {31'h0, busy}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("midrst_evt_valid", {31'h0, evt_valid}, 32'h0);
    chk("midrst_peak", evt_peak, 32'h0);
    chk("midrst_peak_ts", evt_peak_ts, 32'h0);
    chk("midrst_width", {16'h0, evt_width}, 32'h0);
    chk("midrst_drop", {16'h0, evt_drop_cnt}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk_78_125);
    #1;
    rstn = 1'b1;
    send(32'h40000000);
    send(32'h00000000);
    chk("post_rst_evt_valid", {31'h0, evt_valid}, 32'h1);
    chk("post_rst_peak_ts", evt_peak_ts, 32'd0);
    chk("post_rst_width", {16'h0, evt_width}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/a6_pulse_detect.md
A6_PULSE_DETECT -- requirements
Module: a6_pulse_detect

Interface
REQ-001 Parameter THRESH_HI, 32'h3F800000 (1.0), fp32 trigger threshold.
REQ-002 Parameter THRESH_LO, 32'h3F000000 (0.5), fp32 release threshold.
REQ-003 Parameter HOLDOFF, 4, valid samples ignored after each event (0..65535).
REQ-004 Parameter MAX_WIDTH, 64, forced pulse end length in samples (1..65535).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk_78_125 and rstn.
REQ-006 Port clk_78_125  input  1  sole clock.
REQ-007 Port rstn  input  1  asynchronous active-low reset.
REQ-008 Port din_valid  input  1  a6_0 valid this cycle; driven by decompose_L6 dout_valid.
REQ-009 Port a6_0  input  32  fp32 level-6 approximation sample.
REQ-010 Port evt_valid  output  1  event register holds an event.
REQ-011 Port evt_ready  input  1  consumer accepts event.
REQ-012 Port evt_peak  output  32  fp32 peak value.
REQ-013 Port evt_peak_ts  output  32  sample index of the peak.
REQ-014 Port evt_width  output  16  pulse length in samples.
REQ-015 Port evt_drop_cnt  output  16  events lost to backpressure.
REQ-016 Port busy  output  1  state is not IDLE.

Function
REQ-017 fp32 compares SHALL use key(x) = x[31] ? ~x : x ^ 32'h80000000, compared unsigned; -0 < +0; NaN ordered by key, with no special handling.
REQ-018 A 32-bit sample counter ts SHALL tag each valid sample with its current value, then increment; it wraps 0xFFFFFFFF -> 0.
REQ-019 Cycles with din_valid=0 SHALL change no state, counter or pulse register.
REQ-020 States SHALL be IDLE, PULSE and HOLDOFF.
REQ-021 IDLE: a valid sample with key > key(THRESH_HI) SHALL move to PULSE and set peak=sample, peak_ts=ts, width=1.
REQ-022 PULSE: a valid sample with key < key(THRESH_LO) SHALL end the pulse; that sample is excluded from width and peak.
REQ-023 PULSE, otherwise: width SHALL increment, and peak/peak_ts SHALL update only on strictly greater key (the first maximum is kept).
REQ-024 PULSE: when width reaches MAX_WIDTH, the pulse SHALL end after that sample (forced end), with width=MAX_WIDTH.
REQ-025 Pulse end SHALL emit the event and load a holdoff counter with HOLDOFF.
REQ-026 After pulse end the block SHALL enter HOLDOFF, or IDLE if HOLDOFF=0.
REQ-027 HOLDOFF: each valid sample SHALL decrement the counter and is otherwise ignored; at 0 the block SHALL enter IDLE, and the next valid sample is evaluated in IDLE.
REQ-028 Event latency: evt_valid and the evt_* fields SHALL be registered on the clock edge that samples the terminating input.
REQ-029 evt_valid SHALL stay high, with fields stable, until an edge with evt_ready=1.
REQ-030 An edge with evt_ready=1 and no new event SHALL clear evt_valid.
REQ-031 A new event with evt_valid=0, or with evt_valid=1 and evt_ready=1 on the same edge, SHALL load the register and hold evt_valid=1.
REQ-032 A new event with evt_valid=1 and evt_ready=0 SHALL be dropped; the held event is kept and evt_drop_cnt increments, saturating at 0xFFFF.
REQ-033 busy SHALL be registered and equal (state != IDLE).

Reset
REQ-034 While rstn=0, state SHALL be IDLE and ts, peak, width, holdoff counter and all outputs SHALL be 0.
REQ-035 Reset mid-pulse SHALL discard the pulse without emitting an event.
REQ-036 After release, the first valid sample SHALL get ts=0.

Verification
REQ-037 Basic: samples 3E800000, 40000000, 40400000, 40000000, 3E800000 (ts 0..4) -> one event, peak=40400000, peak_ts=2, width=3; evt_valid rises on the ts4 edge.
REQ-038 Hysteresis/tie: 40000000, 3F400000, 40000000, 3E800000 -> width=3, peak=40000000, peak_ts=0.
REQ-039 Sign: BF800000, 80000000, 3F800000 (equal to THRESH_HI) -> no event, busy=0 throughout.
REQ-040 Backpressure: evt_ready=0, two pulses separated by more than HOLDOFF samples -> first event held unchanged, evt_drop_cnt=1.
REQ-041 Simultaneous accept: a second event arrives on the same edge as evt_ready=1 -> second event loaded, evt_valid stays 1, evt_drop_cnt=0.
REQ-042 Forced end and reset: 70 samples of 40000000 -> event width=64, peak_ts=0; new pulse starts at ts=68. Asserting rstn=0 at ts=69 -> no event, all outputs 0, next sample gets ts=0.
